// File: rtl/approx_mul_pipe.sv
// rtl/approx_mul_pipe.sv - pipelined run-time configurable approximate unsigned multiplier
module approx_mul_pipe #(
  parameter int W  = 8,
  parameter int TW = $clog2(W),
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic [TW-1:0]   cfg_trunc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_p,
  output logic [TW-1:0]   out_trunc,
  output logic [CW-1:0]   txn_cnt
);

  localparam int PW = 2 * W;
  localparam logic [TW-1:0] TMAX = TW'(W - 1);

  logic          s1_valid;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  logic [TW-1:0] s1_t;
  logic          s1_nz;

  logic          s2_load;
  logic          accept;
  logic          advance;
  logic [TW-1:0] t_eff;
  logic [PW-1:0] sum;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid && s2_load;
  assign t_eff    = (cfg_trunc > TMAX) ? TMAX : cfg_trunc;

  // Column-masked reduction: partial products below column T are dropped with no carry-in.
  always_comb begin
    sum = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if ((i + j) >= int'(s1_t)) begin
          sum = sum + (PW'(s1_a[i] & s1_b[j]) << (i + j));
        end
      end
    end
    if ((s1_t != '0) && s1_nz) begin
      sum = sum + (PW'(1) << (s1_t - TW'(1)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_t     <= '0;
      s1_nz    <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_t     <= t_eff;
      s1_nz    <= (in_a != '0) && (in_b != '0);
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_trunc <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_p     <= sum;
        out_trunc <= s1_t;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= '0;
    end else if (out_valid && out_ready) begin
      txn_cnt <= txn_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// tb/tb_approx_mul_pipe.sv - scoreboard bench for approx_mul_pipe
module tb_approx_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic [2:0]  cfg_trunc, out_trunc;
  logic [15:0] out_p, txn_cnt;

  logic        in2_valid, in2_ready, out2_valid, out2_ready;
  logic [5:0]  in2_a, in2_b;
  logic [2:0]  cfg2, out2_trunc;
  logic [11:0] out2_p;
  logic [3:0]  txn_cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [18:0] exp_q[$];
  logic [11:0] q2[$];
  int          inflight = 0;
  logic [15:0] exp_cnt = '0;
  logic        stalled_prev = 1'b0;
  logic [15:0] held_p;
  logic [2:0]  held_t;
  int          rdy_mode = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  approx_mul_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .cfg_trunc(cfg_trunc),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_trunc(out_trunc),
    .txn_cnt(txn_cnt)
  );

  approx_mul_pipe #(.W(6), .CW(4)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in2_valid), .in_ready(in2_ready), .in_a(in2_a), .in_b(in2_b), .cfg_trunc(cfg2),
    .out_valid(out2_valid), .out_ready(out2_ready), .out_p(out2_p), .out_trunc(out2_trunc),
    .txn_cnt(txn_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: exact product minus the dropped low columns, plus rounding compensation.
  function automatic int unsigned ref_mul(input int w, input int unsigned a, input int unsigned b,
                                          input int t);
    int unsigned drop;
    int unsigned r;
    int te;
    te = (t > w - 1) ? w - 1 : t;
    drop = 0;
    for (int c = 0; c < te; c++)
      for (int i = 0; i <= c; i++)
        if (i < w && (c - i) < w)
          drop += (((a >> i) & 1) & ((b >> (c - i)) & 1)) << c;
    r = a * b - drop;
    if (te > 0 && a != 0 && b != 0) r += (1 << (te - 1));
    return r;
  endfunction

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] t,
                      input logic [15:0] ep, input logic [2:0] et);
    in_valid = 1'b1; in_a = a; in_b = b; cfg_trunc = t;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    exp_q.push_back({et, ep});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [7:0] a, input logic [7:0] b, input logic [2:0] t);
    send(a, b, t, 16'(ref_mul(8, a, b, int'(t))), t);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 500; n++) begin
      @(posedge clk); #2;
      if (inflight == 0 && exp_q.size() == 0) break;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    cyc++;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial forever begin
    logic [18:0] e;
    @(negedge clk);
    if (!rst_n) begin
      inflight = 0; exp_cnt = '0; stalled_prev = 1'b0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready || inflight < 2);
      chk("txn_cnt", txn_cnt, exp_cnt);
      if (stalled_prev && out_valid) begin
        chk("hold_p", out_p, held_p);
        chk("hold_t", out_trunc, held_t);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sb_empty", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_p", out_p, e[15:0]);
          chk("out_trunc", out_trunc, e[18:16]);
        end
        exp_cnt++;
        inflight--;
      end
      if (in_valid && in_ready) inflight++;
      stalled_prev = out_valid && !out_ready;
      held_p = out_p;
      held_t = out_trunc;
    end
  end

  initial forever begin
    logic [11:0] e2;
    @(negedge clk);
    if (rst_n && out2_valid && out2_ready) begin
      if (q2.size() == 0) chk("sb6_empty", 1, 0);
      else begin
        e2 = q2.pop_front();
        chk("p6", out2_p, e2);
        chk("t6", out2_trunc, 5);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; cfg_trunc = '0; out_ready = 1'b1;
    in2_valid = 1'b0; in2_a = '0; in2_b = '0; cfg2 = '0; out2_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_out_trunc", out_trunc, 0);
    chk("rst_txn_cnt", txn_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Latency: presented at cycle start, visible after the second edge.
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255; cfg_trunc = 3'd0;
    exp_q.push_back({3'd0, 16'd65025});
    @(posedge clk); #1 in_valid = 1'b0;
    chk("lat_edge1", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_edge2", out_valid, 1);
    chk("lat_p", out_p, 65025);

    send(8'd0,   8'd200, 3'd0, 16'd0,     3'd0);
    send(8'd17,  8'd3,   3'd0, 16'd51,    3'd0);
    send(8'd255, 8'd255, 3'd4, 16'd64984, 3'd4);
    send(8'd15,  8'd15,  3'd4, 16'd184,   3'd4);
    send(8'd0,   8'd255, 3'd4, 16'd0,     3'd4);
    send(8'd255, 8'd255, 3'd7, 16'd64320, 3'd7);
    send(8'd255, 8'd255, 3'd0, 16'd65025, 3'd0);
    send(8'd255, 8'd255, 3'd4, 16'd64984, 3'd4);
    send(8'd255, 8'd255, 3'd0, 16'd65025, 3'd0);
    wait_idle();

    begin
      logic [15:0] base;
      base = exp_cnt;
      rdy_mode = 1;
      for (int k = 0; k < 8; k++)
        send_rand(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
      wait_idle();
      chk("bp_cnt", txn_cnt, base + 16'd8);
    end

    rdy_mode = 2;
    for (int k = 0; k < 10000; k++)
      send_rand(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
    rdy_mode = 0;
    wait_idle();

    send_rand(8'd200, 8'd100, 3'd3);
    send_rand(8'd99,  8'd77,  3'd5);
    #1;
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_flush", out_valid, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
    end
    chk("rst_cnt", txn_cnt, 0);

    for (int k = 0; k < 17; k++) begin
      @(posedge clk); #1;
      in2_valid = 1'b1;
      in2_a = 6'($urandom_range(0, 63));
      in2_b = (k == 0) ? 6'd63 : 6'($urandom_range(0, 63));
      if (k == 0) in2_a = 6'd63;
      cfg2 = 3'd7;
      q2.push_back(12'(ref_mul(6, in2_a, in2_b, 7)));
      @(negedge clk);
      chk("in2_ready", in2_ready, 1);
    end
    @(posedge clk); #1 in2_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #2;
      if (q2.size() == 0 && !out2_valid) break;
    end
    chk("drain6", q2.size(), 0);
    chk("wrap_cnt", txn_cnt2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
